// File: rtl/dphy_tx_pkg.sv
// Shared D-PHY transmit definitions: lane state encoding, sync byte and
// default timing values (HS_BYTE_CLK cycles), used by data and clock lanes.
// Optional ULPS states exist only when TX_DATA_ULPS_EN is defined.
package dphy_tx_pkg;

   localparam int unsigned TIMER_W      = 5;
   localparam logic [7:0]  HS_SYNC_BYTE = 8'hB8;

   localparam int unsigned DEF_TLPX        = 1;
   localparam int unsigned DEF_THS_PREPARE = 2;
   localparam int unsigned DEF_THS_ZERO    = 4;
   localparam int unsigned DEF_THS_TRAIL   = 2;
   localparam int unsigned DEF_THS_EXIT    = 2;
   localparam int unsigned DEF_TWAKEUP     = 4;

   typedef enum logic [3:0] {
      ST_STOP       = 4'd0,
      ST_HS_RQST    = 4'd1,
      ST_HS_PREPARE = 4'd2,
      ST_HS_ZERO    = 4'd3,
      ST_HS_SYNC    = 4'd4,
      ST_HS_DATA    = 4'd5,
      ST_HS_TRAIL   = 4'd6,
`ifdef TX_DATA_ULPS_EN
      ST_HS_EXIT    = 4'd7,
      ST_ULPS_RQST  = 4'd8,
      ST_ULPS       = 4'd9,
      ST_ULPS_EXIT  = 4'd10
`else
      ST_HS_EXIT    = 4'd7
`endif
   } lane_state_t;

endpackage

// File: rtl/tx_data_lane_if.sv
// PPI-side bundle of the data lane. master = burst source, slave = lane.
// Handshake: a byte on TxDataHS is taken on a rising edge where TxReadyHS
// and TxRequestHS are both 1; TxReadyHS does not depend on TxRequestHS.
// state_dbg mirrors the lane FSM state for observation only.
interface tx_data_lane_if;
   import dphy_tx_pkg::*;

   logic        enable;
   logic        DATA_LANE_START;
   logic        TxRequestHS;
   logic [7:0]  TxDataHS;
   logic        TxUlpsEsc;
   logic        TxUlpsExit;
   logic        TxReadyHS;
   logic [7:0]  HS_DATA;
   logic        HS_EN;
   logic        DATA_DP;
   logic        DATA_DN;
   logic        STOP_STATE;
   logic        ULPS_ACTIVE_NOT;
   lane_state_t state_dbg;

   modport master (
      output enable, DATA_LANE_START, TxRequestHS, TxDataHS, TxUlpsEsc, TxUlpsExit,
      input  TxReadyHS, HS_DATA, HS_EN, DATA_DP, DATA_DN, STOP_STATE,
             ULPS_ACTIVE_NOT, state_dbg
   );

   modport slave (
      input  enable, DATA_LANE_START, TxRequestHS, TxDataHS, TxUlpsEsc, TxUlpsExit,
      output TxReadyHS, HS_DATA, HS_EN, DATA_DP, DATA_DN, STOP_STATE,
             ULPS_ACTIVE_NOT, state_dbg
   );

endinterface

// File: rtl/tx_dl_timer.sv
// Load/down-counter for the timed lane states. The lane loads (duration-1)
// when entering a timed state; done is high while the count is zero, which
// is the last cycle of that state.
module tx_dl_timer
   import dphy_tx_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               done
);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   // Next count: reload on state entry, otherwise count down to zero and hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/tx_data_lane.sv
// D-PHY HS data lane transmitter: LP request/prepare sequence, HS zero and
// sync, payload with 1-cycle latency, trail and exit back to LP-11 STOP.
// Define TX_DATA_ULPS_EN to build the ULPS entry/exit states.
module tx_data_lane
   import dphy_tx_pkg::*;
#(
   parameter int unsigned TLPX        = DEF_TLPX,
   parameter int unsigned THS_PREPARE = DEF_THS_PREPARE,
   parameter int unsigned THS_ZERO    = DEF_THS_ZERO,
   parameter int unsigned THS_TRAIL   = DEF_THS_TRAIL,
   parameter int unsigned THS_EXIT    = DEF_THS_EXIT,
   parameter int unsigned TWAKEUP     = DEF_TWAKEUP
)
(
   input  logic           HS_BYTE_CLK,
   input  logic           TxRst,
   tx_data_lane_if.slave  lane
);

   lane_state_t        state_q, state_d;
   logic [7:0]         last_q, last_d;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_done;

   logic               ready;
   logic               hs_en;
   logic [7:0]         hs_data;
   logic               dp, dn;
   logic               stop_st;
   logic               ulps_act;

`ifndef TX_DATA_ULPS_EN
   logic               ulps_inputs_unused;
   assign ulps_inputs_unused = lane.TxUlpsEsc ^ lane.TxUlpsExit;
`endif

   tx_dl_timer u_timer (
      .clk      (HS_BYTE_CLK),
      .rst      (TxRst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next state and last-byte register; enable/DATA_LANE_START only matter in STOP.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      if (ready && lane.TxRequestHS) begin
         last_d = lane.TxDataHS;
      end
      case (state_q)
         ST_STOP: begin
            if (lane.enable && lane.TxRequestHS && lane.DATA_LANE_START) begin
               state_d = ST_HS_RQST;
            end
`ifdef TX_DATA_ULPS_EN
            else if (lane.TxUlpsEsc) begin
               state_d = ST_ULPS_RQST;
            end
`endif
         end
         ST_HS_RQST:    if (tmr_done) state_d = ST_HS_PREPARE;
         ST_HS_PREPARE: if (tmr_done) state_d = ST_HS_ZERO;
         ST_HS_ZERO:    if (tmr_done) state_d = ST_HS_SYNC;
         ST_HS_SYNC: begin
            if (lane.TxRequestHS) begin
               state_d = ST_HS_DATA;
            end else begin
               // Empty burst: trail follows the sync byte, so invert its MSB.
               state_d = ST_HS_TRAIL;
               last_d  = HS_SYNC_BYTE;
            end
         end
         ST_HS_DATA:    if (!lane.TxRequestHS) state_d = ST_HS_TRAIL;
         ST_HS_TRAIL:   if (tmr_done) state_d = ST_HS_EXIT;
         ST_HS_EXIT:    if (tmr_done) state_d = ST_STOP;
`ifdef TX_DATA_ULPS_EN
         ST_ULPS_RQST:  if (tmr_done) state_d = ST_ULPS;
         ST_ULPS:       if (lane.TxUlpsExit) state_d = ST_ULPS_EXIT;
         ST_ULPS_EXIT:  if (tmr_done) state_d = ST_STOP;
`endif
         default:       state_d = ST_STOP;
      endcase
   end

   // Timer reload whenever a new state is entered; untimed states load zero.
   always_comb begin
      tmr_load = (state_d != state_q);
      tmr_val  = '0;
      case (state_d)
         ST_HS_RQST:    tmr_val = TIMER_W'(TLPX - 1);
         ST_HS_PREPARE: tmr_val = TIMER_W'(THS_PREPARE - 1);
         ST_HS_ZERO:    tmr_val = TIMER_W'(THS_ZERO - 1);
         ST_HS_TRAIL:   tmr_val = TIMER_W'(THS_TRAIL - 1);
         ST_HS_EXIT:    tmr_val = TIMER_W'(THS_EXIT - 1);
`ifdef TX_DATA_ULPS_EN
         ST_ULPS_RQST:  tmr_val = TIMER_W'(TLPX - 1);
         ST_ULPS_EXIT:  tmr_val = TIMER_W'(TWAKEUP - 1);
`endif
         default:       tmr_val = '0;
      endcase
   end

   // State and last-byte registers; reset aborts any burst without a trail.
   always_ff @(posedge HS_BYTE_CLK) begin
      if (TxRst) begin
         state_q <= ST_STOP;
         last_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Moore output decode of the registered state.
   always_comb begin
      ready    = 1'b0;
      hs_en    = 1'b0;
      hs_data  = 8'h00;
      dp       = 1'b0;
      dn       = 1'b0;
      stop_st  = 1'b0;
      ulps_act = 1'b0;
      case (state_q)
         ST_STOP: begin
            dp      = 1'b1;
            dn      = 1'b1;
            stop_st = 1'b1;
         end
         ST_HS_RQST: dn = 1'b1;
         ST_HS_PREPARE: ;
         ST_HS_ZERO: hs_en = 1'b1;
         ST_HS_SYNC: begin
            hs_en   = 1'b1;
            ready   = 1'b1;
            hs_data = HS_SYNC_BYTE;
         end
         ST_HS_DATA: begin
            hs_en   = 1'b1;
            ready   = 1'b1;
            hs_data = last_q;
         end
         ST_HS_TRAIL: begin
            hs_en   = 1'b1;
            hs_data = {8{~last_q[7]}};
         end
         ST_HS_EXIT: begin
            dp = 1'b1;
            dn = 1'b1;
         end
`ifdef TX_DATA_ULPS_EN
         ST_ULPS_RQST: dp = 1'b1;
         ST_ULPS:      ulps_act = 1'b1;
         ST_ULPS_EXIT: dp = 1'b1;
`endif
         default: ;
      endcase
   end

   assign lane.TxReadyHS       = ready;
   assign lane.HS_EN           = hs_en;
   assign lane.HS_DATA         = hs_data;
   assign lane.DATA_DP         = dp;
   assign lane.DATA_DN         = dn;
   assign lane.STOP_STATE      = stop_st;
   assign lane.ULPS_ACTIVE_NOT = ulps_act;
   assign lane.state_dbg       = state_q;

endmodule

// File: tb/tb_tx_data_lane.sv
// Bench for tx_data_lane: builds the expected per-cycle line/byte trace of
// each scenario from the lane timing rules and compares it every cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tx_data_lane;

   localparam int T_LPX   = 1;
   localparam int T_PREP  = 2;
   localparam int T_ZERO  = 4;
   localparam int T_TRAIL = 2;
   localparam int T_EXIT  = 2;
   localparam int T_WAKE  = 4;

   // Observation vector: {stop, ulps, ready, hs_en, dp, dn, data[7:0]}
   localparam logic [13:0] OBS_STOP = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [13:0] exp_q[$];

   tx_data_lane_if lane_if ();

   tx_data_lane dut (
      .HS_BYTE_CLK (clk),
      .TxRst       (rst),
      .lane        (lane_if)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic logic [13:0] sample();
      return {lane_if.STOP_STATE, lane_if.ULPS_ACTIVE_NOT, lane_if.TxReadyHS, lane_if.HS_EN,
              lane_if.DATA_DP, lane_if.DATA_DN, lane_if.HS_DATA};
   endfunction

   function automatic logic [13:0] e_lp(input bit dp, input bit dn, input bit ulps);
      return {1'b0, ulps, 1'b0, 1'b0, dp, dn, 8'h00};
   endfunction

   function automatic logic [13:0] e_hs(input bit ready, input logic [7:0] d);
      return {1'b0, 1'b0, ready, 1'b1, 1'b0, 1'b0, d};
   endfunction

   task automatic idle_inputs();
      lane_if.enable          = 1'b1;
      lane_if.DATA_LANE_START = 1'b1;
      lane_if.TxRequestHS     = 1'b0;
      lane_if.TxDataHS        = 8'($urandom);
      lane_if.TxUlpsEsc       = 1'b0;
      lane_if.TxUlpsExit      = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] got;
      rst = 1'b1;
      lane_if.enable          = 1'b1;
      lane_if.DATA_LANE_START = 1'b1;
      lane_if.TxRequestHS     = 1'b1;
      lane_if.TxDataHS        = 8'($urandom);
      lane_if.TxUlpsEsc       = 1'b1;
      lane_if.TxUlpsExit      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== OBS_STOP) begin
            errors++;
            $display("FAIL reset cycle %0d: got %h required %h", i, got, OBS_STOP);
         end
      end
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== OBS_STOP) begin
         errors++;
         $display("FAIL reset_release: got %h required %h", got, OBS_STOP);
      end
   endtask

   // Missing DATA_LANE_START or enable keeps the lane in STOP.
   task automatic test_stop_hold();
      logic [13:0] got;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = sample();
            checks++;
            if (got !== OBS_STOP) begin
               errors++;
               $display("FAIL stop_hold cycle %0d: got %h required %h", i, got, OBS_STOP);
            end
         end
         lane_if.TxRequestHS     = 1'b1;
         lane_if.enable          = (i >= 5) ? 1'b0 : 1'b1;
         lane_if.DATA_LANE_START = (i >= 5) ? 1'b1 : 1'b0;
         lane_if.TxDataHS        = 8'($urandom);
      end
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== OBS_STOP) begin
         errors++;
         $display("FAIL stop_hold final: got %h required %h", got, OBS_STOP);
      end
      idle_inputs();
   endtask

   // One HS burst of n bytes; abort_at >= 0 pulses reset in that burst cycle.
   task automatic test_burst(input string name, input logic [7:0] b[8], input int n,
                             input bit esc, input int abort_at);
      logic [13:0] got, e;
      logic [7:0]  trail;
      int          pre, total;
      pre = T_LPX + T_PREP + T_ZERO;
      exp_q.delete();
      for (int i = 0; i < T_LPX; i++)  exp_q.push_back(e_lp(1'b0, 1'b1, 1'b0));
      for (int i = 0; i < T_PREP; i++) exp_q.push_back(e_lp(1'b0, 1'b0, 1'b0));
      for (int i = 0; i < T_ZERO; i++) exp_q.push_back(e_hs(1'b0, 8'h00));
      exp_q.push_back(e_hs(1'b1, 8'hB8));
      for (int k = 0; k < n; k++)      exp_q.push_back(e_hs(1'b1, b[k]));
      trail = (n == 0) ? 8'h00 : (b[n-1][7] ? 8'h00 : 8'hFF);
      for (int i = 0; i < T_TRAIL; i++) exp_q.push_back(e_hs(1'b0, trail));
      for (int i = 0; i < T_EXIT; i++)  exp_q.push_back(e_lp(1'b1, 1'b1, 1'b0));
      exp_q.push_back(OBS_STOP);
      total = exp_q.size();

      @(negedge clk);
      lane_if.enable          = 1'b1;
      lane_if.DATA_LANE_START = 1'b1;
      lane_if.TxRequestHS     = 1'b1;
      lane_if.TxUlpsEsc       = esc;
      lane_if.TxDataHS        = 8'($urandom);
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, c, got, e);
         end
         if (c == 1) begin
            // Dropping these mid-burst must not disturb it.
            lane_if.enable          = 1'($urandom_range(0, 1));
            lane_if.DATA_LANE_START = 1'($urandom_range(0, 1));
            lane_if.TxUlpsEsc       = 1'b0;
         end
         if (c == abort_at) begin
            lane_if.TxRequestHS = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            for (int j = 0; j < 3; j++) begin
               got = sample();
               checks++;
               if (got !== OBS_STOP) begin
                  errors++;
                  $display("FAIL %s after_reset %0d: got %h required %h", name, j, got, OBS_STOP);
               end
               @(negedge clk);
            end
            exp_q.delete();
            idle_inputs();
            return;
         end
         lane_if.TxRequestHS = (c < pre + n) ? 1'b1 : 1'b0;
         lane_if.TxDataHS    = (c >= pre && c < pre + n) ? b[c-pre] : 8'($urandom);
      end
      idle_inputs();
   endtask

   task automatic test_ulps();
      logic [13:0] got, e;
      int          h, total;
`ifdef TX_DATA_ULPS_EN
      h = $urandom_range(1, 5);
      exp_q.delete();
      for (int i = 0; i < T_LPX; i++)  exp_q.push_back(e_lp(1'b1, 1'b0, 1'b0));
      for (int i = 0; i < h; i++)      exp_q.push_back(e_lp(1'b0, 1'b0, 1'b1));
      for (int i = 0; i < T_WAKE; i++) exp_q.push_back(e_lp(1'b1, 1'b0, 1'b0));
      exp_q.push_back(OBS_STOP);
      total = exp_q.size();
      @(negedge clk);
      lane_if.DATA_LANE_START = 1'b0;
      lane_if.TxRequestHS     = 1'b1;
      lane_if.TxUlpsEsc       = 1'b1;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL ulps cycle %0d: got %h required %h", c, got, e);
         end
         lane_if.TxUlpsEsc   = 1'b0;
         lane_if.TxRequestHS = 1'b0;
         lane_if.TxUlpsExit  = (c == T_LPX + h - 1) ? 1'b1 : 1'b0;
      end
`else
      h = 0;
      total = 6;
      @(negedge clk);
      lane_if.DATA_LANE_START = 1'b0;
      lane_if.TxRequestHS     = 1'b1;
      lane_if.TxUlpsEsc       = 1'b1;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== OBS_STOP) begin
            errors++;
            $display("FAIL ulps_ignored cycle %0d: got %h required %h", c + h, got, OBS_STOP);
         end
         lane_if.TxUlpsExit = 1'($urandom_range(0, 1));
      end
`endif
      idle_inputs();
      @(negedge clk);
   endtask

   // Scenario sequence and summary.
   initial begin
      logic [7:0] b[8];
      int         n;
      test_reset();
      test_stop_hold();

      b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      test_burst("burst_112233", b, 3, 1'b0, -1);

      b = '{8'h5A, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      test_burst("trail_after_80", b, 2, 1'b0, -1);

      b = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      test_burst("trail_after_7f", b, 1, 1'b0, -1);

      test_burst("empty_burst", b, 0, 1'b0, -1);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
         n = $urandom_range(1, 8);
         test_burst("random_burst_hs_over_ulps", b, n, 1'b1, -1);
      end

      b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
      test_burst("reset_mid_burst", b, 4, 1'b0, T_LPX + T_PREP + T_ZERO + 2);

      test_ulps();

      for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
      test_burst("burst_after_ulps", b, 5, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_data_lane.md
TX_DATA_LANE -- requirements
Module: tx_data_lane

Interface
REQ-001 SHALL have parameters (name, default, meaning), all in HS_BYTE_CLK cycles, legal range 1..31: TLPX, 1, LP-01 / LP-10 request duration.
REQ-002 SHALL have parameters THS_PREPARE, 2, LP-00 duration; THS_ZERO, 4, HS-zero bytes; THS_TRAIL, 2, trail bytes; THS_EXIT, 2, LP-11 exit; TWAKEUP, 4, ULPS exit LP-10.
REQ-003 SHALL have port HS_BYTE_CLK, in, 1, the single byte clock; all logic is on its rising edge.
REQ-004 SHALL have port TxRst, in, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have ports: enable, in, 1, lane enable; DATA_LANE_START, in, 1, clock lane is in HS clocking; TxRequestHS, in, 1, HS burst request; TxDataHS, in, 8, payload byte.
REQ-006 SHALL have ports: TxUlpsEsc, in, 1, ULPS request; TxUlpsExit, in, 1, ULPS exit request.
REQ-007 SHALL have ports: TxReadyHS, out, 1, byte accepted; HS_DATA, out, 8, byte to the serializer; HS_EN, out, 1, HS driver enable; DATA_DP, out, 1, and DATA_DN, out, 1, LP line levels; STOP_STATE, out, 1; ULPS_ACTIVE_NOT, out, 1.

Function
REQ-008 SHALL implement the states STOP, HS_RQST, HS_PREPARE, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT, ULPS_RQST, ULPS and ULPS_EXIT.
REQ-009 SHALL leave STOP for HS_RQST when enable, TxRequestHS and DATA_LANE_START are all 1; HS takes priority over TxUlpsEsc when both are requested.
REQ-010 SHALL hold each timed state for exactly its parameter in cycles, then advance: HS_RQST (TLPX) to HS_PREPARE (THS_PREPARE) to HS_ZERO (THS_ZERO) to HS_SYNC (1 cycle) to HS_DATA.
REQ-011 SHALL remain in HS_DATA while TxRequestHS is 1; when TxRequestHS is 0, the next state is HS_TRAIL (THS_TRAIL), then HS_EXIT (THS_EXIT), then STOP.
REQ-012 SHALL drive TxReadyHS = 1 only in HS_SYNC and HS_DATA; a byte is accepted on an edge where TxReadyHS and TxRequestHS are both 1, and is captured into the last-byte register.
REQ-013 SHALL drive HS_DATA as follows: 0x00 in HS_ZERO; 0xB8 in HS_SYNC; the last-byte register in HS_DATA; {8{~last[7]}} in HS_TRAIL; 0x00 otherwise. This gives 1-cycle latency from acceptance to output.
REQ-014 SHALL, if TxRequestHS is 0 during HS_SYNC, go to HS_TRAIL with last = 0xB8, so the trail byte is 0x00.
REQ-015 SHALL drive HS_EN = 1 exactly in HS_ZERO, HS_SYNC, HS_DATA and HS_TRAIL.
REQ-016 SHALL drive (DATA_DP, DATA_DN) as: LP11 in STOP and HS_EXIT; LP01 in HS_RQST; LP00 in HS_PREPARE and ULPS; LP10 in ULPS_RQST and ULPS_EXIT; 00 while HS_EN = 1.
REQ-017 SHALL drive STOP_STATE = 1 only in STOP, and ULPS_ACTIVE_NOT = 1 only in ULPS.
REQ-018 SHALL sample enable and DATA_LANE_START only in STOP; a deassertion of either mid-burst SHALL NOT abort the burst.
REQ-019 SHALL make all outputs except the last-byte register Moore decodes of the registered state.

Reset
REQ-020 SHALL, on TxRst = 1 at a clock edge, go to STOP from any state including mid-burst; no trail is sent.
REQ-021 SHALL, in reset, set last = 0x00 and the timer to 0, with outputs TxReadyHS = 0, HS_EN = 0, HS_DATA = 0x00, DATA_DP = 1, DATA_DN = 1, STOP_STATE = 1, ULPS_ACTIVE_NOT = 0.

Configuration
REQ-022 SHALL compile ULPS support in only when TX_DATA_ULPS_EN is defined. With it: STOP goes to ULPS_RQST on TxUlpsEsc; ULPS_RQST (TLPX) goes to ULPS; ULPS holds until TxUlpsExit, then goes to ULPS_EXIT (TWAKEUP), then STOP.
REQ-023 SHALL, without TX_DATA_ULPS_EN, ignore TxUlpsEsc and TxUlpsExit, omit the ULPS states, and tie ULPS_ACTIVE_NOT to 0.

Structure
REQ-024 SHALL place the state encoding localparams, the sync byte constant 0xB8 and the default timing values in a shared package, dphy_tx_pkg, used with the clock lane.
REQ-025 SHALL contain one sub-module, tx_dl_timer: a 5-bit load/down-counter that pulses done on the last cycle of each timed state.

Verification
REQ-026 SHALL verify that with defaults, raising TxRequestHS with DATA_LANE_START = 1 gives LP01 x1, LP00 x2, 0x00 x4, 0xB8 x1, then the bytes 0x11, 0x22, 0x33 on consecutive cycles.
REQ-027 SHALL verify that a last byte 0x80, followed by dropping TxRequestHS, gives trail 0x00 x2, then LP11 x2, then STOP_STATE = 1.
REQ-028 SHALL verify that a last byte 0x7F, followed by dropping TxRequestHS, gives trail 0xFF x2.
REQ-029 SHALL verify that with DATA_LANE_START = 0 and TxRequestHS = 1, the lane stays in STOP; with TxUlpsEsc also 1 and TX_DATA_ULPS_EN defined, the lane enters ULPS_RQST.
REQ-030 SHALL verify that TxRst pulsed on the 2nd HS_DATA byte gives STOP outputs, including LP11, on the next cycle.
REQ-031 SHALL verify the ULPS sequence TxUlpsEsc, then TxUlpsExit, giving LP10 x1, LP00 with ULPS_ACTIVE_NOT = 1, LP10 x4, then STOP.
